// File: rtl/matrix_mult_seq_if.sv
// matrix_mult_seq_if: handshake and operand/result buses for matrix_mult_seq.
//   master: request side (start, signed_mode, abort, a_flat, b_flat, out_ready)
//   slave : engine side  (in_ready, c_flat, out_valid, busy)
// Element (r,c) of a_flat/b_flat sits at [(r*N+c)*DW +: DW]; c_flat uses ACC_W-wide slots.
interface matrix_mult_seq_if #(
  parameter int unsigned N     = 2,
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 2 * DW + $clog2(N)
);
  logic                   start;
  logic                   in_ready;
  logic                   signed_mode;
  logic                   abort;
  logic [N*N*DW-1:0]      a_flat;
  logic [N*N*DW-1:0]      b_flat;
  logic [N*N*ACC_W-1:0]   c_flat;
  logic                   out_valid;
  logic                   out_ready;
  logic                   busy;

  modport master (
    output start, signed_mode, abort, a_flat, b_flat, out_ready,
    input  in_ready, c_flat, out_valid, busy
  );

  modport slave (
    input  start, signed_mode, abort, a_flat, b_flat, out_ready,
    output in_ready, c_flat, out_valid, busy
  );
endinterface

// File: rtl/matrix_mult_seq.sv
// matrix_mult_seq: NxN matrix multiplier C = A x B using one time-shared MAC, one MAC per cycle.
// Ports:
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - matrix_mult_seq_if.slave: start/in_ready request handshake, signed_mode, abort,
//         a_flat/b_flat operands, c_flat result with out_valid/out_ready, busy status
// Operands and mode are captured when start is accepted in IDLE; results are produced row-major
// and C[N-1][N-1] is written N^3 edges after the accepting edge, at which point out_valid rises.
module matrix_mult_seq #(
  parameter int unsigned N     = 2,
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 2 * DW + $clog2(N)
) (
  input logic               clk,
  input logic               rst,
  matrix_mult_seq_if.slave  bus
);
  localparam int unsigned IW = $clog2(N);
  localparam int unsigned XW = ACC_W - DW;

  typedef enum logic [1:0] {StIdle, StCompute, StDone} state_e;

  state_e             r_state, w_state_next;
  logic [DW-1:0]      r_a [N][N];
  logic [DW-1:0]      r_b [N][N];
  logic [ACC_W-1:0]   r_c [N][N];
  logic               r_signed;
  logic [IW-1:0]      r_i, r_j, r_k;
  logic [ACC_W-1:0]   r_acc;

  logic [DW-1:0]          w_a_in [N][N];
  logic [DW-1:0]          w_b_in [N][N];
  logic [N*N*ACC_W-1:0]   w_c_flat;
  logic                   w_capture, w_mac;
  logic                   w_last_i, w_last_j, w_last_k;
  logic [DW-1:0]          w_a_elem, w_b_elem;
  logic [ACC_W-1:0]       w_a_ext, w_b_ext, w_prod, w_sum;

  // Unpack inputs and pack the result with constant slices.
  for (genvar gr = 0; gr < N; gr++) begin : g_row
    for (genvar gc = 0; gc < N; gc++) begin : g_col
      assign w_a_in[gr][gc] = bus.a_flat[(gr*N+gc)*DW +: DW];
      assign w_b_in[gr][gc] = bus.b_flat[(gr*N+gc)*DW +: DW];
      assign w_c_flat[(gr*N+gc)*ACC_W +: ACC_W] = r_c[gr][gc];
    end
  end

  assign bus.c_flat    = w_c_flat;
  assign bus.in_ready  = (r_state == StIdle);
  assign bus.busy      = (r_state == StCompute);
  assign bus.out_valid = (r_state == StDone);

  assign w_last_i = (r_i == IW'(N - 1));
  assign w_last_j = (r_j == IW'(N - 1));
  assign w_last_k = (r_k == IW'(N - 1));

  // Operand extension: replicate the sign bit only in signed mode. Truncating the ACC_W x ACC_W
  // product to ACC_W bits gives the correct two's-complement result modulo 2^ACC_W.
  always_comb begin
    w_a_elem = r_a[r_i][r_k];
    w_b_elem = r_b[r_k][r_j];
    w_a_ext  = {{XW{r_signed & w_a_elem[DW-1]}}, w_a_elem};
    w_b_ext  = {{XW{r_signed & w_b_elem[DW-1]}}, w_b_elem};
    w_prod   = w_a_ext * w_b_ext;
    w_sum    = r_acc + w_prod;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_mac        = 1'b0;
    unique case (r_state)
      StIdle: begin
        // start has priority over abort here; abort is meaningless in IDLE.
        if (bus.start) begin
          w_capture    = 1'b1;
          w_state_next = StCompute;
        end
      end
      StCompute: begin
        if (bus.abort) begin
          w_state_next = StIdle;
        end else begin
          w_mac = 1'b1;
          if (w_last_i && w_last_j && w_last_k) begin
            w_state_next = StDone;
          end
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '{default: '0};
      r_b      <= '{default: '0};
      r_c      <= '{default: '0};
      r_signed <= 1'b0;
      r_i      <= '0;
      r_j      <= '0;
      r_k      <= '0;
      r_acc    <= '0;
    end else begin
      if (w_capture) begin
        r_a      <= w_a_in;
        r_b      <= w_b_in;
        r_signed <= bus.signed_mode;
        r_i      <= '0;
        r_j      <= '0;
        r_k      <= '0;
        r_acc    <= '0;
      end
      if (w_mac) begin
        if (w_last_k) begin
          // Element finished: commit it and step to the next (i,j) in row-major order.
          r_c[r_i][r_j] <= w_sum;
          r_acc         <= '0;
          r_k           <= '0;
          if (w_last_j) begin
            r_j <= '0;
            r_i <= w_last_i ? '0 : r_i + 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end else begin
          r_acc <= w_sum;
          r_k   <= r_k + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_matrix_mult_seq.sv
// tb_matrix_mult_seq: self-checking bench for matrix_mult_seq (N=2 and N=3 instances).
module tb_matrix_mult_seq;
  logic clk;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;

  matrix_mult_seq_if #(.N(2), .DW(8), .ACC_W(17)) if2 ();
  matrix_mult_seq_if #(.N(3), .DW(8), .ACC_W(18)) if3 ();

  matrix_mult_seq #(.N(2), .DW(8), .ACC_W(17)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  matrix_mult_seq #(.N(3), .DW(8), .ACC_W(18)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sm;
    logic [67:0] c;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
  endtask

  // Reference: C[r][c] = sum_k A[r][k]*B[k][c] in plain integers, reduced modulo 2^17.
  function automatic logic [67:0] model2(input logic [31:0] a, input logic [31:0] b,
                                         input logic sm);
    logic [67:0] res;
    logic [7:0]  x, y;
    int          s, xv, yv;
    res = '0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        s = 0;
        for (int k = 0; k < 2; k++) begin
          x  = 8'(a >> (8 * (r * 2 + k)));
          y  = 8'(b >> (8 * (k * 2 + c)));
          xv = sm ? int'($signed(x)) : int'({24'd0, x});
          yv = sm ? int'($signed(y)) : int'({24'd0, y});
          s  = s + xv * yv;
        end
        res = res | (68'(s[16:0]) << (17 * (r * 2 + c)));
      end
    end
    return res;
  endfunction

  task automatic wait_valid2(output int lat);
    lat = 0;
    while (!if2.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Start a job; operands are scrambled right after the accepting edge.
  task automatic run2(input logic [31:0] a, input logic [31:0] b, input logic sm,
                      output logic [67:0] c, output int lat, output logic bsy);
    @(negedge clk);
    if2.a_flat = a; if2.b_flat = b; if2.signed_mode = sm; if2.start = 1'b1;
    @(posedge clk); #1;
    if2.start = 1'b0; if2.a_flat = ~a; if2.b_flat = ~b; if2.signed_mode = ~sm;
    bsy = if2.busy;
    wait_valid2(lat);
    c = if2.c_flat;
  endtask

  task automatic drain2();
    @(negedge clk); if2.out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); if2.out_ready = 1'b0;
  endtask

  task automatic chk_c2(input string tag, input logic [67:0] got, input logic [67:0] exp);
    for (int e = 0; e < 4; e++)
      chk($sformatf("%s_c%0d", tag, e), 128'(17'(got >> (17 * e))), 128'(17'(exp >> (17 * e))));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [67:0] got, exp;
    logic [31:0] a, b;
    logic        sm, bsy;
    logic [71:0] a3, b3;
    int          lat, seen;

    tbl[0] = '{a: {8'd4, 8'd3, 8'd2, 8'd1}, b: {8'd8, 8'd7, 8'd6, 8'd5}, sm: 1'b0,
               c: {17'd50, 17'd43, 17'd22, 17'd19}};
    tbl[1] = '{a: {8'hFC, 8'd3, 8'd2, 8'hFF}, b: {8'd8, 8'd7, 8'd6, 8'd5}, sm: 1'b1,
               c: {17'h1FFF2, 17'h1FFF3, 17'd10, 17'd9}};
    tbl[2] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, sm: 1'b0, c: {4{17'd130050}}};
    tbl[3] = '{a: 32'h8080_8080, b: 32'h8080_8080, sm: 1'b1, c: {4{17'd32768}}};

    rst = 1'b1;
    if2.start = 0; if2.signed_mode = 0; if2.abort = 0; if2.a_flat = '0; if2.b_flat = '0;
    if2.out_ready = 0;
    if3.start = 0; if3.signed_mode = 0; if3.abort = 0; if3.a_flat = '0; if3.b_flat = '0;
    if3.out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(if2.in_ready), 128'(1));
    chk("rst_out_valid", 128'(if2.out_valid), 128'(0));
    chk("rst_busy", 128'(if2.busy), 128'(0));
    chk("rst_c_flat", 128'(if2.c_flat), 128'(0));
    chk("rst3_in_ready", 128'(if3.in_ready), 128'(1));
    @(negedge clk); rst = 1'b0;

    // Directed vectors.
    for (int i = 0; i < 4; i++) begin
      run2(tbl[i].a, tbl[i].b, tbl[i].sm, got, lat, bsy);
      chk($sformatf("tbl%0d_busy", i), 128'(bsy), 128'(1));
      chk($sformatf("tbl%0d_latency", i), 128'(lat), 128'(8));
      chk_c2($sformatf("tbl%0d", i), got, tbl[i].c);
      drain2();
    end

    // Randomized operands vs. reference model.
    for (int it = 0; it < 6; it++) begin
      a = $urandom; b = $urandom; sm = 1'($urandom_range(0, 1));
      run2(a, b, sm, got, lat, bsy);
      chk($sformatf("rnd%0d_latency", it), 128'(lat), 128'(8));
      chk_c2($sformatf("rnd%0d", it), got, model2(a, b, sm));
      drain2();
    end

    // Backpressure: result held while out_ready=0, start and operands ignored.
    a = $urandom; b = $urandom; sm = 1'b1;
    run2(a, b, sm, got, lat, bsy);
    exp = model2(a, b, sm);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if2.start = ~if2.start; if2.a_flat = $urandom; if2.out_ready = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("bp%0d_valid", c), 128'(if2.out_valid), 128'(1));
      chk($sformatf("bp%0d_c_flat", c), 128'(if2.c_flat), 128'(exp));
    end
    a = $urandom; b = $urandom; sm = 1'b0;
    @(negedge clk);
    if2.out_ready = 1'b1; if2.start = 1'b1;
    if2.a_flat = a; if2.b_flat = b; if2.signed_mode = sm;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 128'(if2.in_ready), 128'(1));
    chk("bp_release_valid", 128'(if2.out_valid), 128'(0));
    @(negedge clk); if2.out_ready = 1'b0;
    @(posedge clk); #1;
    chk("bp_next_start_busy", 128'(if2.busy), 128'(1));
    if2.start = 1'b0;
    wait_valid2(lat);
    chk("bp_next_latency", 128'(lat), 128'(8));
    chk_c2("bp_next", if2.c_flat, model2(a, b, sm));
    drain2();

    // Abort on the third COMPUTE cycle.
    @(negedge clk);
    if2.a_flat = $urandom; if2.b_flat = $urandom; if2.start = 1'b1;
    @(posedge clk); #1; if2.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk); if2.abort = 1'b1;
    @(posedge clk); #1; if2.abort = 1'b0;
    chk("abort_in_ready", 128'(if2.in_ready), 128'(1));
    chk("abort_busy", 128'(if2.busy), 128'(0));
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (if2.out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("abort_no_valid", 128'(seen), 128'(0));
    a = $urandom; b = $urandom; sm = 1'b1;
    run2(a, b, sm, got, lat, bsy);
    chk("post_abort_latency", 128'(lat), 128'(8));
    chk_c2("post_abort", got, model2(a, b, sm));
    drain2();

    // Reset in the middle of COMPUTE (after C[0][0] is already written).
    @(negedge clk);
    if2.a_flat = 32'h0403_0201; if2.b_flat = 32'h0807_0605; if2.start = 1'b1;
    @(posedge clk); #1; if2.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1;
    chk("midrst_in_ready", 128'(if2.in_ready), 128'(1));
    chk("midrst_busy", 128'(if2.busy), 128'(0));
    chk("midrst_valid", 128'(if2.out_valid), 128'(0));
    chk("midrst_c_flat", 128'(if2.c_flat), 128'(0));
    @(negedge clk); rst = 1'b0;

    // N=3: identity x B gives B back after 27 cycles.
    a3 = '0; b3 = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        if (r == c) a3 = a3 | (72'(1) << (8 * (r * 3 + c)));
        b3 = b3 | (72'(r * 3 + c + 1) << (8 * (r * 3 + c)));
      end
    @(negedge clk);
    if3.a_flat = a3; if3.b_flat = b3; if3.signed_mode = 1'b0; if3.start = 1'b1;
    @(posedge clk); #1; if3.start = 1'b0; if3.a_flat = '0;
    lat = 0;
    while (!if3.out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("n3_latency", 128'(lat), 128'(27));
    for (int e = 0; e < 9; e++)
      chk($sformatf("n3_c%0d", e), 128'(18'(if3.c_flat >> (18 * e))), 128'(e + 1));
    @(negedge clk); if3.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("n3_drain_in_ready", 128'(if3.in_ready), 128'(1));
    if3.out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/matrix_mult_seq.md
Name: matrix_mult_seq

Overview:
Parametrised NxN matrix multiplier, C = A x B, built around one time-shared multiply-accumulate unit.
- Replaces the fixed 2x2 combinational-MAC engine with a generic N-dimension, DW-width engine.
- Adds signed/unsigned mode, a ready/valid handshake with output backpressure, and synchronous abort.
- Sits between the operand staging registers and the result consumer in the matrix datapath.

Parameters:
N, 2, matrix dimension (N >= 2)
DW, 8, operand element width in bits
ACC_W, 2*DW+$clog2(N), result element width; with the default, no overflow is possible in either mode

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  request to begin; accepted only when in_ready=1
in_ready  out  1  high in IDLE only
signed_mode  in  1  1 = two's-complement operands and results, 0 = unsigned; sampled with start
abort  in  1  synchronous cancel of a computation in progress
a_flat  in  N*N*DW  matrix A; element (r,c) at bits [(r*N+c)*DW +: DW]
b_flat  in  N*N*DW  matrix B; same packing as a_flat
c_flat  out  N*N*ACC_W  matrix C; element (r,c) at bits [(r*N+c)*ACC_W +: ACC_W]
out_valid  out  1  c_flat is complete and stable
out_ready  in  1  consumer accepts the result
busy  out  1  high in COMPUTE

Behaviour:
- Reset (asynchronous, any state): state=IDLE, in_ready=1, out_valid=0, busy=0, c_flat=0, i=j=k=0, acc=0, captured operands=0, mode=0.
- States: IDLE, COMPUTE, DONE.
- IDLE:
  - start=1 at an edge: capture a_flat, b_flat and signed_mode into internal registers; clear i, j, k and acc; go to COMPUTE.
  - The input buses may change after the accepting edge without affecting the result.
- COMPUTE (one MAC per cycle):
  - Each edge computes p = A[i][k]*B[k][j], operands extended per the captured mode to ACC_W.
  - k<N-1: acc <= acc+p; k++.
  - k==N-1: C[i][j] <= acc+p; acc <= 0; k <= 0; advance j, then i on j wrap (row-major).
  - After the edge that writes C[N-1][N-1], go to DONE.
  - Latency: start accepted at edge T means C[N-1][N-1] is written and out_valid rises at edge T+N^3 (8 cycles for N=2).
- c_flat update rule:
  - Elements update individually as each finishes; untouched elements keep their prior value.
  - c_flat is guaranteed consistent only while out_valid=1.
- DONE:
  - out_valid=1; c_flat is held stable.
  - out_ready=1 at an edge: out_valid <= 0; go to IDLE. The earliest next start is accepted one edge later.
  - start is ignored in COMPUTE and DONE; it is not queued.
- abort:
  - In COMPUTE: go to IDLE at that edge. out_valid is never raised; partially written c_flat elements remain.
  - In IDLE or DONE: no effect. The DONE result must be drained with out_ready.
  - abort and start both high in IDLE: start wins.
- Arithmetic:
  - Unsigned mode: zero-extend operands.
  - Signed mode: sign-extend operands; products and sums are ACC_W two's complement.
  - Results wrap modulo 2^ACC_W; wrap is unreachable with the default ACC_W.
- Reset mid-COMPUTE or mid-DONE: immediate return to the reset values; no output pulse.

Test Plan:
1. Unsigned N=2: A=[1,2;3,4], B=[5,6;7,8], start -> out_valid exactly 8 cycles after the accepting edge, C=[19,22;43,50].
2. Signed N=2: A=[-1,2;3,-4], B=[5,6;7,8] -> C=[9,10;-13,-14] (17-bit two's complement).
3. Extremes:
   - Unsigned, all elements 255 -> every C element = 130050.
   - Signed, all elements -128 -> every C element = 32768; no wrap.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid; toggle start and a_flat meanwhile -> c_flat and out_valid stable, start ignored; out_ready=1 -> IDLE next edge; a following start is accepted one edge later.
5. Abort on the 3rd COMPUTE cycle -> IDLE next edge; out_valid stays 0; in_ready=1; a fresh start then completes correctly.
6. Reset asserted mid-COMPUTE and released -> all outputs at reset values; N=3 instance with A=identity and B=1..9 -> C=B, out_valid after 27 cycles.
